// File: rtl/hazard_unit_if.sv
// Handshake bundle between the pipeline control path and the hazard unit.
// The pipeline side drives decode/EX status and consumes the stall/flush controls.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] rs1_de;
  logic [REG_W-1:0] rs2_de;
  logic             rs1_used_de;
  logic             rs2_used_de;
  logic [REG_W-1:0] rd_ex;
  logic             DMRd_ex;
  logic             md_start_ex;
  logic             br_taken_ex;
  logic             clr;
  logic             pc_inc_de;
  logic             pc_fe;
  logic             flush_fd;
  logic             ex_hold;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_de, rs2_de, rs1_used_de, rs2_used_de, rd_ex, DMRd_ex,
           md_start_ex, br_taken_ex,
    input  clr, pc_inc_de, pc_fe, flush_fd, ex_hold, stall_cycles
  );

  modport slave (
    input  rs1_de, rs2_de, rs1_used_de, rs2_used_de, rd_ex, DMRd_ex,
           md_start_ex, br_taken_ex,
    output clr, pc_inc_de, pc_fe, flush_fd, ex_hold, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, multi-cycle mul/div EX holds,
// taken-branch flushes, and a saturating count of fetch-stalled cycles.
module hazard_unit #(
  parameter int REG_W     = 5,
  parameter int LD_STALL  = 1,
  parameter int MD_LAT    = 4,
  parameter int IGNORE_X0 = 1,
  parameter int CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_STALL = 2'd1,
    S_MD_BUSY  = 2'd2
  } state_t;

  // The first stall/hold cycle is spent in IDLE, so the counters preload one (or two) short.
  localparam bit         LD_MULTI = (LD_STALL > 1);
  localparam bit         MD_MULTI = (MD_LAT > 1);
  localparam bit         MD_BUSY_USED = (MD_LAT > 2);
  localparam logic [3:0] LD_INIT = 4'(LD_STALL - 1);
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cntNext;
  logic [CNT_W-1:0] r_stallCycles;

  logic w_rdValid;
  logic w_loadUse;
  logic w_clr;
  logic w_pcIncDe;
  logic w_pcFe;
  logic w_flushFd;
  logic w_exHold;

  assign w_rdValid = !((IGNORE_X0 != 0) && (bus.rd_ex == REG_W'(0)));
  assign w_loadUse = bus.DMRd_ex && w_rdValid &&
                     ((bus.rs1_used_de && (bus.rs1_de == bus.rd_ex)) ||
                      (bus.rs2_used_de && (bus.rs2_de == bus.rd_ex)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_stallCycles <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (!w_pcFe && (r_stallCycles != {CNT_W{1'b1}})) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_clr       = 1'b0;
    w_pcIncDe   = 1'b1;
    w_pcFe      = 1'b1;
    w_flushFd   = 1'b0;
    w_exHold    = 1'b0;
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    if (rst) begin
      w_stateNext = S_IDLE;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.br_taken_ex) begin
            w_flushFd   = 1'b1;
            w_clr       = 1'b1;
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
          end else if (bus.md_start_ex && MD_MULTI) begin
            w_exHold  = 1'b1;
            w_pcIncDe = 1'b0;
            w_pcFe    = 1'b0;
            if (MD_BUSY_USED) begin
              w_stateNext = S_MD_BUSY;
              w_cntNext   = MD_INIT;
            end
          end else if (w_loadUse) begin
            w_clr     = 1'b1;
            w_pcIncDe = 1'b0;
            w_pcFe    = 1'b0;
            if (LD_MULTI) begin
              w_stateNext = S_LD_STALL;
              w_cntNext   = LD_INIT;
            end
          end
        end
        S_LD_STALL: begin
          if (bus.br_taken_ex) begin
            w_flushFd   = 1'b1;
            w_clr       = 1'b1;
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
          end else begin
            w_clr     = 1'b1;
            w_pcIncDe = 1'b0;
            w_pcFe    = 1'b0;
            if (r_cnt <= 4'd1) begin
              w_stateNext = S_IDLE;
              w_cntNext   = '0;
            end else begin
              w_cntNext = r_cnt - 4'd1;
            end
          end
        end
        S_MD_BUSY: begin
          w_exHold  = 1'b1;
          w_pcIncDe = 1'b0;
          w_pcFe    = 1'b0;
          if (r_cnt <= 4'd1) begin
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt - 4'd1;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  assign bus.clr          = w_clr;
  assign bus.pc_inc_de    = w_pcIncDe;
  assign bus.pc_fe        = w_pcFe;
  assign bus.flush_fd     = w_flushFd;
  assign bus.ex_hold      = w_exHold;
  assign bus.stall_cycles = r_stallCycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench: instance A uses default timing, instance B uses a 3-cycle
// load stall and a 4-bit counter to exercise multi-cycle stalls and saturation.
module tb_hazard_unit;

  logic clk;
  logic rstA;
  logic rstB;
  int   checks;
  int   errors;

  hazard_unit_if #(.REG_W(5), .CNT_W(16)) ifA ();
  hazard_unit_if #(.REG_W(5), .CNT_W(4))  ifB ();

  hazard_unit #(
    .REG_W(5), .LD_STALL(1), .MD_LAT(4), .IGNORE_X0(1), .CNT_W(16)
  ) dutA (
    .clk(clk),
    .rst(rstA),
    .bus(ifA.slave)
  );

  hazard_unit #(
    .REG_W(5), .LD_STALL(3), .MD_LAT(4), .IGNORE_X0(1), .CNT_W(4)
  ) dutB (
    .clk(clk),
    .rst(rstB),
    .bus(ifB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One call is one clock cycle: inputs change just after the edge, outputs settle mid-cycle.
  task automatic applyStimulus(input bit sel, input bit r, input bit dmrd,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input bit u1, input logic [4:0] rs2, input bit u2,
                               input bit md, input bit br);
    @(posedge clk);
    #1;
    if (!sel) begin
      rstA = r; ifA.DMRd_ex = dmrd; ifA.rd_ex = rd; ifA.rs1_de = rs1;
      ifA.rs1_used_de = u1; ifA.rs2_de = rs2; ifA.rs2_used_de = u2;
      ifA.md_start_ex = md; ifA.br_taken_ex = br;
    end else begin
      rstB = r; ifB.DMRd_ex = dmrd; ifB.rd_ex = rd; ifB.rs1_de = rs1;
      ifB.rs1_used_de = u1; ifB.rs2_de = rs2; ifB.rs2_used_de = u2;
      ifB.md_start_ex = md; ifB.br_taken_ex = br;
    end
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstA = 1'b1;
    rstB = 1'b1;
    ifA.DMRd_ex = 0; ifA.rd_ex = 0; ifA.rs1_de = 0; ifA.rs1_used_de = 0;
    ifA.rs2_de = 0; ifA.rs2_used_de = 0; ifA.md_start_ex = 0; ifA.br_taken_ex = 0;
    ifB.DMRd_ex = 0; ifB.rd_ex = 0; ifB.rs1_de = 0; ifB.rs1_used_de = 0;
    ifB.rs2_de = 0; ifB.rs2_used_de = 0; ifB.md_start_ex = 0; ifB.br_taken_ex = 0;

    $display("[TB] instance A: LD_STALL=1, MD_LAT=4");
    applyStimulus(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    applyStimulus(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("A_rst_clr", 32'(ifA.clr), 0);
    checkOutput("A_rst_pcfe", 32'(ifA.pc_fe), 1);
    checkOutput("A_rst_pcinc", 32'(ifA.pc_inc_de), 1);
    checkOutput("A_rst_cnt", 32'(ifA.stall_cycles), 0);

    applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("A_lu_clr", 32'(ifA.clr), 1);
    checkOutput("A_lu_pcfe", 32'(ifA.pc_fe), 0);
    checkOutput("A_lu_pcinc", 32'(ifA.pc_inc_de), 0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_lu_after_clr", 32'(ifA.clr), 0);
    checkOutput("A_lu_after_pcfe", 32'(ifA.pc_fe), 1);
    checkOutput("A_lu_cnt", 32'(ifA.stall_cycles), 1);

    applyStimulus(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    checkOutput("A_x0_clr", 32'(ifA.clr), 0);
    checkOutput("A_x0_pcfe", 32'(ifA.pc_fe), 1);
    applyStimulus(0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0);
    checkOutput("A_rs2unused_clr", 32'(ifA.clr), 0);
    applyStimulus(0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0);
    checkOutput("A_rs2used_clr", 32'(ifA.clr), 1);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_rs2_cnt", 32'(ifA.stall_cycles), 2);

    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("A_md1_hold", 32'(ifA.ex_hold), 1);
    checkOutput("A_md1_pcfe", 32'(ifA.pc_fe), 0);
    checkOutput("A_md1_pcinc", 32'(ifA.pc_inc_de), 0);
    checkOutput("A_md1_clr", 32'(ifA.clr), 0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    checkOutput("A_md2_hold", 32'(ifA.ex_hold), 1);
    checkOutput("A_md2_br_ignored", 32'(ifA.flush_fd), 0);
    checkOutput("A_md2_clr", 32'(ifA.clr), 0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_md3_hold", 32'(ifA.ex_hold), 1);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_md_done_hold", 32'(ifA.ex_hold), 0);
    checkOutput("A_md_done_pcfe", 32'(ifA.pc_fe), 1);
    checkOutput("A_md_cnt", 32'(ifA.stall_cycles), 5);

    applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1);
    checkOutput("A_br_flush", 32'(ifA.flush_fd), 1);
    checkOutput("A_br_clr", 32'(ifA.clr), 1);
    checkOutput("A_br_pcfe", 32'(ifA.pc_fe), 1);
    checkOutput("A_br_pcinc", 32'(ifA.pc_inc_de), 1);

    applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0);
    checkOutput("A_mdlu_hold", 32'(ifA.ex_hold), 1);
    checkOutput("A_mdlu_clr", 32'(ifA.clr), 0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_mdlu3_hold", 32'(ifA.ex_hold), 1);
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("A_mdlu_done_hold", 32'(ifA.ex_hold), 0);
    checkOutput("A_mdlu_cnt", 32'(ifA.stall_cycles), 8);

    $display("[TB] instance B: LD_STALL=3, MD_LAT=4, CNT_W=4");
    applyStimulus(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    applyStimulus(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_rst_cnt", 32'(ifB.stall_cycles), 0);
    applyStimulus(1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("B_ld1_clr", 32'(ifB.clr), 1);
    checkOutput("B_ld1_pcfe", 32'(ifB.pc_fe), 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_ld2_clr", 32'(ifB.clr), 1);
    checkOutput("B_ld2_pcinc", 32'(ifB.pc_inc_de), 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_ld3_pcfe", 32'(ifB.pc_fe), 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_ld_done_clr", 32'(ifB.clr), 0);
    checkOutput("B_ld_done_pcfe", 32'(ifB.pc_fe), 1);
    checkOutput("B_ld_cnt", 32'(ifB.stall_cycles), 3);

    applyStimulus(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    applyStimulus(1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("B_abort1_pcfe", 32'(ifB.pc_fe), 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    checkOutput("B_abort_flush", 32'(ifB.flush_fd), 1);
    checkOutput("B_abort_clr", 32'(ifB.clr), 1);
    checkOutput("B_abort_pcfe", 32'(ifB.pc_fe), 1);
    checkOutput("B_abort_pcinc", 32'(ifB.pc_inc_de), 1);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_abort_next_clr", 32'(ifB.clr), 0);
    checkOutput("B_abort_next_flush", 32'(ifB.flush_fd), 0);
    checkOutput("B_abort_cnt", 32'(ifB.stall_cycles), 1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    end
    checkOutput("B_sat_clr", 32'(ifB.clr), 0);
    checkOutput("B_sat_cnt", 32'(ifB.stall_cycles), 15);

    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    checkOutput("B_md1_hold", 32'(ifB.ex_hold), 1);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_md2_hold", 32'(ifB.ex_hold), 1);
    applyStimulus(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_mdrst_hold", 32'(ifB.ex_hold), 0);
    checkOutput("B_mdrst_pcfe", 32'(ifB.pc_fe), 1);
    checkOutput("B_mdrst_pcinc", 32'(ifB.pc_inc_de), 1);
    checkOutput("B_mdrst_cnt_held", 32'(ifB.stall_cycles), 15);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("B_postrst_cnt", 32'(ifB.stall_cycles), 0);
    checkOutput("B_postrst_hold", 32'(ifB.ex_hold), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
